// File: rtl/lut_neuron_reloadable_if.sv
`default_nettype none
// ============================================================================
//  Module   : lut_neuron_reloadable_if
//  Brief    : Config, inference-input and result handshakes of the LUT neuron.
//  Revision : 1.0
// ============================================================================
interface lut_neuron_reloadable_if #(
    parameter int ADDR_W   = 6,
    parameter int OUT_BITS = 2
);
    logic                cfg_start;
    logic                cfg_valid;
    logic [OUT_BITS-1:0] cfg_data;
    logic                cfg_ready;
    logic                cfg_done;
    logic                in_valid;
    logic [ADDR_W-1:0]   in_data;
    logic                in_ready;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;
    logic                out_ready;

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        output cfg_ready, cfg_done, in_ready, out_valid, out_data
    );

    modport master (
        output cfg_start, cfg_valid, cfg_data, in_valid, in_data, out_ready,
        input  cfg_ready, cfg_done, in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/lut_neuron_reloadable.sv
`default_nettype none
// ============================================================================
//  Module   : lut_neuron_reloadable
//  Brief    : Register-based truth-table neuron with a streaming reload port.
//  Revision : 1.0
// ============================================================================
module lut_neuron_reloadable #(
    parameter int FANIN    = 3,
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    lut_neuron_reloadable_if.slave   bus
);
    localparam int ADDR_W = FANIN * IN_BITS;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [OUT_BITS-1:0] table_q [DEPTH];
    logic [OUT_BITS-1:0] table_d [DEPTH];
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] out_data_q,  out_data_d;
    logic                cfg_done_q,  cfg_done_d;
    logic                w_in_ready;

    // A pending reload request blocks new inputs so it wins over in_valid.
    assign w_in_ready    = (state_q == RUN) && (!out_valid_q || bus.out_ready) && !bus.cfg_start;
    assign bus.in_ready  = w_in_ready;
    assign bus.cfg_ready = (state_q == LOAD);
    assign bus.cfg_done  = cfg_done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        table_d     = table_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        cfg_done_d  = 1'b0;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            EMPTY: begin
                if (bus.cfg_start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                // Restart discards whatever beat shares the cycle.
                if (bus.cfg_start) begin
                    addr_d = '0;
                end else if (bus.cfg_valid) begin
                    table_d[addr_q] = bus.cfg_data;
                    addr_d          = addr_q + 1'b1;
                    if (&addr_q) begin
                        state_d    = RUN;
                        cfg_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (bus.cfg_start) begin
                    addr_d  = '0;
                    state_d = (!out_valid_q || bus.out_ready) ? LOAD : DRAIN;
                end else if (bus.in_valid && w_in_ready) begin
                    out_valid_d = 1'b1;
                    out_data_d  = table_q[bus.in_data];
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            addr_q      <= '0;
            table_q     <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            table_q     <= table_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_done_q  <= cfg_done_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_lut_neuron_reloadable.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lut_neuron_reloadable
//  Brief    : Directed + randomized bench against a table/handshake reference.
//  Revision : 1.0
// ============================================================================
module tb_lut_neuron_reloadable;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk;
    logic rst_n;

    lut_neuron_reloadable_if #(.ADDR_W(ADDR_W), .OUT_BITS(2)) bus ();

    lut_neuron_reloadable #(.FANIN(3), .IN_BITS(2), .OUT_BITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [1:0] ref_tbl [DEPTH];
    bit         exp_valid;
    logic [1:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One inference cycle: check outputs, then advance the result-register model.
    task automatic step(input bit iv, input logic [5:0] id, input bit ordy);
        bit acc;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
        if (exp_valid) chk("out_data", {30'd0, bus.out_data}, {30'd0, exp_data});
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, (!exp_valid || ordy)});
        acc = iv && (!exp_valid || ordy);
        tick();
        if (acc) begin
            exp_valid = 1'b1;
            exp_data  = ref_tbl[id];
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
    endtask

    // pattern 0: a[1:0], 1: constant 2'b10, 2: random
    task automatic load(input bit do_start, input int pattern);
        int a;
        int guard;
        bit v;
        logic [1:0] d;
        logic [5:0] a6;
        if (do_start) begin
            bus.cfg_start = 1'b1;
            tick();
            bus.cfg_start = 1'b0;
        end
        #1;
        chk("cfg_ready_load", {31'd0, bus.cfg_ready}, 32'd1);
        a = 0;
        guard = 0;
        while (a < DEPTH && guard < 1000) begin
            v  = ($urandom_range(0, 3) != 0);
            a6 = a[5:0];
            case (pattern)
                0:       d = a6[1:0];
                1:       d = 2'b10;
                default: d = 2'($urandom);
            endcase
            bus.cfg_valid = v;
            bus.cfg_data  = d;
            #1;
            chk("cfg_done_early", {31'd0, bus.cfg_done}, 32'd0);
            tick();
            if (v) begin
                ref_tbl[a] = d;
                a++;
            end
            guard++;
        end
        bus.cfg_valid = 1'b0;
        chk("load_guard", guard < 1000 ? 32'd1 : 32'd0, 32'd1);
        chk("cfg_done_pulse", {31'd0, bus.cfg_done}, 32'd1);
        chk("cfg_ready_run", {31'd0, bus.cfg_ready}, 32'd0);
        chk("in_ready_run", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("cfg_done_single", {31'd0, bus.cfg_done}, 32'd0);
        exp_valid = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) != 0, 6'($urandom), $urandom_range(0, 2) != 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 2'b00;
        exp_valid = 1'b0;
        exp_data  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 2'b00;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  {30'd0, bus.out_data},  32'd0);
        chk("rst_cfg_done",  {31'd0, bus.cfg_done},  32'd0);
        chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
        bus.in_valid = 1'b1;
        #1;
        chk("empty_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Identity-style table, then back-to-back lookups.
        load(1'b1, 0);
        step(1'b1, 6'b000001, 1'b1);
        step(1'b1, 6'b000110, 1'b1);
        step(1'b0, 6'b000000, 1'b1);
        step(1'b0, 6'b000000, 1'b1);

        // Backpressure hold on a 2'b11 result.
        step(1'b1, 6'd3, 1'b0);
        repeat (3) step(1'b1, 6'd5, 1'b0);
        step(1'b1, 6'd5, 1'b1);
        step(1'b0, 6'd0, 1'b1);
        stream(60);

        // Reload request while a result is stalled goes through DRAIN.
        step(1'b1, 6'd2, 1'b0);
        bus.cfg_start = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        #1;
        chk("start_blocks_in", {31'd0, bus.in_ready}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("drain_in_ready",  {31'd0, bus.in_ready},  32'd0);
            chk("drain_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
            chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("drain_out_data",  {30'd0, bus.out_data},  {30'd0, exp_data});
            tick();
        end
        bus.cfg_start = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("drain_released", {31'd0, bus.out_valid}, 32'd0);
        load(1'b0, 1);
        stream(40);

        // Abort a load after 10 beats; a beat alongside cfg_start is dropped.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        tick();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = 2'b11;
        repeat (10) tick();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        load(1'b0, 2);
        stream(150);

        // Asynchronous reset in the middle of a cycle with a result held.
        step(1'b1, 6'($urandom), 1'b0);
        bus.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_out_data",  {30'd0, bus.out_data},  32'd0);
        chk("arst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("arst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
        bus.in_valid = 1'b0;
        do_reset();

        // Reset during LOAD discards progress; a full reload is required.
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b1;
        repeat (20) tick();
        bus.cfg_valid = 1'b0;
        do_reset();
        load(1'b1, 2);
        stream(150);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
